ps2rx: RTL and testbench



---
 rtl/ps2rx_if.sv | 22 ++
 rtl/ps2rx.sv | 215 +++++++++++++++++++++
 tb/tb_ps2rx.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2rx_if.sv
// ps2rx_if: bundle between the PS/2 pins / consumer and the ps2rx receiver.
//   ps2_clk, ps2_data : PS/2 device lines (asynchronous to clk)
//   inhibit           : host transmitter busy, receiver held idle
//   rd                : pop/acknowledge head byte
//   q, rdy            : head byte and byte-available flag (first-word-fall-through)
//   err, ovf          : one-cycle error / overflow pulses
// slave  = receiver side, master = pins + consumer side.
interface ps2rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       inhibit;
  logic       rd;
  logic [7:0] q;
  logic       rdy;
  logic       err;
  logic       ovf;

  modport slave  (input  ps2_clk, ps2_data, inhibit, rd,
                  output q, rdy, err, ovf);
  modport master (output ps2_clk, ps2_data, inhibit, rd,
                  input  q, rdy, err, ovf);
endinterface

// File: rtl/ps2rx.sv
// ps2rx: PS/2 host-side receiver. Synchronizes and glitch-filters the device
// clock, deframes 11-bit device-to-host frames (start, 8 data LSB-first, odd
// parity, stop) and hands bytes to the consumer through a read-handshake buffer.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : ps2rx_if.slave (ps2_clk, ps2_data, inhibit, rd in; q, rdy, err, ovf out)
//
// Configuration macro PS2RX_FIFO_EN:
//   defined     -> 2**FIFO_AW-entry FIFO
//   not defined -> single holding register (FIFO_AW unused)
module ps2rx #(
  parameter int          FILTER_LEN = 8,
  parameter logic [15:0] TIMEOUT    = 16'd50000,
  parameter int          FIFO_AW    = 3
) (
  input  logic     clk,
  input  logic     reset,
  ps2rx_if.slave   bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  // ---------------- synchronizers + clock filter ----------------
  logic          ck_s1_q, ck_s2_q, dt_s1_q, dt_s2_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          flip, fall;

  // Filtered clock follows the synchronized level only after FILTER_LEN
  // consecutive samples disagreeing with it; any agreeing sample restarts the run.
  assign flip = (ck_s2_q != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
  assign fall = flip && filt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ck_s1_q <= 1'b1;
      ck_s2_q <= 1'b1;
      dt_s1_q <= 1'b1;
      dt_s2_q <= 1'b1;
      filt_q  <= 1'b1;
      fcnt_q  <= '0;
    end else begin
      ck_s1_q <= bus.ps2_clk;
      ck_s2_q <= ck_s1_q;
      dt_s1_q <= bus.ps2_data;
      dt_s2_q <= dt_s1_q;
      if (ck_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (flip) begin
        filt_q <= ck_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FW'(1);
      end
    end
  end

  // ---------------- deframing FSM ----------------
  logic [1:0]  state_q, state_d;
  logic [3:0]  bcnt_q, bcnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic        stop_q, stop_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic        push;
  logic        valid;

  assign valid = ((^sh_q) ^ par_q) && stop_q;

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;
    push    = 1'b0;
    if (bus.inhibit) begin
      state_d = S_IDLE;
      bcnt_d  = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fall && !dt_s2_q) begin
            state_d = S_RECV;
            bcnt_d  = 4'd1;
            tmo_d   = '0;
          end
        end
        S_RECV: begin
          if (fall) begin
            tmo_d  = '0;
            bcnt_d = bcnt_q + 4'd1;
            if (bcnt_q <= 4'd8) begin
              sh_d = {dt_s2_q, sh_q[7:1]};
            end else if (bcnt_q == 4'd9) begin
              par_d = dt_s2_q;
            end else begin
              stop_d  = dt_s2_q;
              state_d = S_CHECK;
            end
          end else if (tmo_q == TIMEOUT - 16'd1) begin
            // device went silent mid-frame: drop the partial byte
            err_d   = 1'b1;
            state_d = S_IDLE;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        S_CHECK: begin
          state_d = S_IDLE;
          if (valid) push  = 1'b1;
          else       err_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.err = err_q;
  assign bus.ovf = ovf_q;

  // ---------------- output buffer ----------------
`ifdef PS2RX_FIFO_EN
  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, rp_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               pop, full, wr;

  assign pop   = bus.rd && (cnt_q != '0);
  assign full  = (cnt_q == (FIFO_AW+1)'(DEPTH));
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr    = push && (!full || pop);
  assign ovf_d = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= sh_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr)  wp_q <= wp_q + FIFO_AW'(1);
      if (pop) rp_q <= rp_q + FIFO_AW'(1);
      cnt_q <= cnt_q + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
    end
  end

  assign bus.rdy = (cnt_q != '0);
  assign bus.q   = bus.rdy ? mem_q[rp_q] : 8'h00;
`else
  logic [7:0] hold_q;
  logic       rdy_q;
  logic       pop;
  logic       unused_aw;

  assign unused_aw = (FIFO_AW != 0);
  assign pop       = bus.rd && rdy_q;
  assign ovf_d     = push && rdy_q && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
      rdy_q  <= 1'b0;
    end else if (push && (!rdy_q || pop)) begin
      hold_q <= sh_q;
      rdy_q  <= 1'b1;
    end else if (pop) begin
      rdy_q  <= 1'b0;
    end
  end

  assign bus.rdy = rdy_q;
  assign bus.q   = rdy_q ? hold_q : 8'h00;
`endif

endmodule

// File: tb/tb_ps2rx.sv
// Bench for ps2rx: 25 MHz clock, PS/2 device model bit-banging frames, a byte
// scoreboard queue modelling the buffer, and pulse counters for err/ovf.
// The PS/2 half-bit period is shortened to H clk cycles so the whole run,
// including the 50000-cycle timeout, stays short; H is still well above the
// clock filter length.
module tb_ps2rx;
  localparam int H = 30;
`ifdef PS2RX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  ps2rx_if bus();

  ps2rx dut (.clk(clk), .reset(reset), .bus(bus));

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] sb[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.err === 1'b1) err_cnt++;
      if (bus.ovf === 1'b1) ovf_cnt++;
    end
  end

  typedef struct {
    logic [7:0] d;
    bit         par_ok;
    bit         stop;
    bit         rd_after;
    bit         exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] d, input bit par_ok, input bit stop);
    logic p;
    p = ~(^d);
    if (!par_ok) p = ~p;
    return {stop, p, d, 1'b0};
  endfunction

  // drives frame bits lo..hi-1; device changes data while the clock is high
  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      bus.ps2_data = f[i];
      cyc(H);
      bus.ps2_clk = 1'b0;
      cyc(H);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    cyc(H);
  endtask

  // buffer model: returns expected ovf for a valid received byte
  function automatic bit model_push(input logic [7:0] d);
    if (sb.size() < CAP) begin
      sb.push_back(d);
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_after(input string nm, input int e0, input int o0,
                             input bit exp_err, input bit exp_ovf);
    cyc(10);
    chk({nm, ".err"}, err_cnt - e0, 32'(exp_err));
    chk({nm, ".ovf"}, ovf_cnt - o0, 32'(exp_ovf));
    chk({nm, ".rdy"}, 32'(bus.rdy), 32'(sb.size() != 0));
    if (sb.size() != 0) chk({nm, ".q"}, 32'(bus.q), 32'(sb[0]));
  endtask

  task automatic do_read(input string nm);
    if (sb.size() == 0) begin
      chk({nm, ".rd_rdy"}, 32'(bus.rdy), 32'd1);
      return;
    end
    chk({nm, ".rd_rdy"}, 32'(bus.rdy), 32'd1);
    chk({nm, ".rd_q"}, 32'(bus.q), 32'(sb[0]));
    bus.rd = 1'b1;
    cyc(1);
    bus.rd = 1'b0;
    void'(sb.pop_front());
    chk({nm, ".after_rd_rdy"}, 32'(bus.rdy), 32'(sb.size() != 0));
    if (sb.size() != 0) chk({nm, ".after_rd_q"}, 32'(bus.q), 32'(sb[0]));
  endtask

  task automatic good_frame(input string nm, input logic [7:0] d, input bit rd_after);
    int e0, o0;
    bit eo;
    e0 = err_cnt;
    o0 = ovf_cnt;
    send_bits(mkframe(d, 1'b1, 1'b1), 0, 11);
    eo = model_push(d);
    check_after(nm, e0, o0, 1'b0, eo);
    if (rd_after) do_read(nm);
  endtask

  initial begin
    vec_t v[3];
    int e0, o0, k, lat;

    v[0] = '{d: 8'h1C, par_ok: 1'b1, stop: 1'b1, rd_after: 1'b1, exp_err: 1'b0};
    v[1] = '{d: 8'hF0, par_ok: 1'b0, stop: 1'b1, rd_after: 1'b0, exp_err: 1'b1};
    v[2] = '{d: 8'h12, par_ok: 1'b1, stop: 1'b0, rd_after: 1'b0, exp_err: 1'b1};

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.inhibit  = 1'b0;
    bus.rd       = 1'b0;
    reset        = 1'b1;
    cyc(5);
    chk("reset.q",   32'(bus.q),   32'h0);
    chk("reset.rdy", 32'(bus.rdy), 32'h0);
    chk("reset.err", 32'(bus.err), 32'h0);
    chk("reset.ovf", 32'(bus.ovf), 32'h0);
    reset = 1'b0;
    cyc(20);

    // table-driven frames
    for (int i = 0; i < 3; i++) begin
      bit eo;
      e0 = err_cnt;
      o0 = ovf_cnt;
      send_bits(mkframe(v[i].d, v[i].par_ok, v[i].stop), 0, 11);
      eo = 1'b0;
      if (!v[i].exp_err) eo = model_push(v[i].d);
      check_after($sformatf("vec%0d", i), e0, o0, v[i].exp_err, eo);
      if (v[i].rd_after) do_read($sformatf("vec%0d", i));
    end

    // timeout: start + 4 data bits then clock parked high
    e0 = err_cnt;
    send_bits(mkframe(8'hE7, 1'b1, 1'b1), 0, 5);
    k = 0;
    while (bus.err !== 1'b1 && k < 60000) begin
      cyc(1);
      k++;
    end
    lat = 2 * H + k;
    chk("timeout.seen", 32'(bus.err === 1'b1), 32'd1);
    chk("timeout.window", 32'(lat >= 50000 && lat <= 50030), 32'd1);
    cyc(5);
    chk("timeout.pulses", err_cnt - e0, 32'd1);
    chk("timeout.rdy", 32'(bus.rdy), 32'd0);
    good_frame("post_timeout", 8'h5A, 1'b1);

    // short low glitch with data low while idle must not start a frame
    e0 = err_cnt;
    bus.ps2_data = 1'b0;
    bus.ps2_clk  = 1'b0;
    cyc(3);
    bus.ps2_clk  = 1'b1;
    cyc(20);
    bus.ps2_data = 1'b1;
    cyc(H);
    chk("glitch.err", err_cnt - e0, 32'd0);
    chk("glitch.rdy", 32'(bus.rdy), 32'd0);
    good_frame("post_glitch", 8'hA5, 1'b1);

    // inhibit raised after 5 bits; remainder of the frame is ignored
    e0 = err_cnt;
    o0 = ovf_cnt;
    send_bits(mkframe(8'h3C, 1'b1, 1'b1), 0, 5);
    bus.inhibit = 1'b1;
    send_bits(mkframe(8'h3C, 1'b1, 1'b1), 5, 11);
    cyc(H);
    bus.inhibit = 1'b0;
    cyc(H);
    check_after("inhibit", e0, o0, 1'b0, 1'b0);
    good_frame("post_inhibit", 8'h3C, 1'b1);

    // overflow: CAP+1 frames without reading
    for (int i = 1; i <= CAP + 1; i++) good_frame($sformatf("fill%0d", i), 8'(i), 1'b0);
    for (int i = 0; i < CAP; i++) do_read($sformatf("drain%0d", i));
    chk("drain.rdy", 32'(bus.rdy), 32'd0);

    // reset mid-frame with a byte held
    good_frame("pre_reset", 8'h77, 1'b0);
    send_bits(mkframe(8'h88, 1'b1, 1'b1), 0, 4);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    sb.delete();
    cyc(1);
    chk("midreset.q",   32'(bus.q),   32'h0);
    chk("midreset.rdy", 32'(bus.rdy), 32'h0);
    chk("midreset.err", 32'(bus.err), 32'h0);
    chk("midreset.ovf", 32'(bus.ovf), 32'h0);
    cyc(20);
    good_frame("post_reset", 8'h42, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
